// File: rtl/jtsdram_check.sv
// SDRAM read-back checker: compares each accepted word against a 16-bit LFSR sequence.
// Define JTSDRAM_ERRADDR_EN to build the first-error address capture register.
module jtsdram_check #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int unsigned AW   = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dwnld_busy,
    input  logic          start,
    input  logic          rd_valid,
    input  logic [15:0]   rd_data,
    output logic          rd_ready,
    output logic          bad,
    output logic [7:0]    err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic [AW-1:0] addr,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   lfsr_next;
    logic          bad_q, bad_d;
    logic [7:0]    err_q, err_d;
    logic          accept, mismatch, last_word;

    // A word arriving during a download is dropped without comparison.
    assign accept    = rd_valid && (state_q == StRun) && !dwnld_busy;
    assign mismatch  = accept && (rd_data != lfsr_q);
    assign last_word = &addr_q;
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (dwnld_busy) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (accept && last_word) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        rd_ready = (state_q == StRun);
        done     = (state_q == StDone) && !dwnld_busy;
    end

    always_comb begin
        addr_d = addr_q;
        lfsr_d = lfsr_q;
        bad_d  = bad_q;
        err_d  = err_q;
        if (dwnld_busy) begin
            addr_d = '0;
            lfsr_d = SEED;
            bad_d  = 1'b0;
            err_d  = 8'd0;
        end else if (state_q == StIdle && start) begin
            addr_d = '0;
            lfsr_d = SEED;
        end else if (accept) begin
            addr_d = addr_q + AW'(1);
            lfsr_d = lfsr_next;
            if (mismatch) begin
                bad_d = 1'b1;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            lfsr_q <= SEED;
            bad_q  <= 1'b0;
            err_q  <= 8'd0;
        end else begin
            addr_q <= addr_d;
            lfsr_q <= lfsr_d;
            bad_q  <= bad_d;
            err_q  <= err_d;
        end
    end

    assign addr    = addr_q;
    assign bad     = bad_q;
    assign err_cnt = err_q;

`ifdef JTSDRAM_ERRADDR_EN
    logic [AW-1:0] first_q, first_d;

    // Only the very first mismatch since reset/download is recorded.
    always_comb begin
        first_d = first_q;
        if (dwnld_busy) begin
            first_d = '0;
        end else if (mismatch && err_q == 8'd0) begin
            first_d = addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= '0;
        end else begin
            first_q <= first_d;
        end
    end

    assign first_err_addr = first_q;
`else
    assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_jtsdram_check.sv
// Self-checking bench for jtsdram_check with AW=4 (16-word passes).
// Works with or without JTSDRAM_ERRADDR_EN defined.
module tb_jtsdram_check;

    localparam int          AW   = 4;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef JTSDRAM_ERRADDR_EN
    localparam bit ErrAddrEn = 1'b1;
`else
    localparam bit ErrAddrEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dwnld_busy = 1'b0;
    logic          start = 1'b0;
    logic          rd_valid = 1'b0;
    logic [15:0]   rd_data = 16'h0000;
    logic          rd_ready;
    logic          bad;
    logic [7:0]    err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] addr;
    logic          done;

    jtsdram_check #(.SEED(SEED), .AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dwnld_busy     (dwnld_busy),
        .start          (start),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_ready       (rd_ready),
        .bad            (bad),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .addr           (addr),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state of the sticky/result outputs
    logic          m_bad;
    logic [7:0]    m_err;
    logic [AW-1:0] m_first;

    typedef struct {
        logic [AW-1:0] addr;
        logic          bad;
        logic [7:0]    err;
        logic [AW-1:0] first;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0]   mask;
        logic [7:0]    exp_err;
        logic          exp_bad;
        logic [AW-1:0] exp_first;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_bad   = 1'b0;
        m_err   = 8'd0;
        m_first = '0;
    endtask

    task automatic model_mismatch(input logic [AW-1:0] a);
        if (m_err == 8'd0 && ErrAddrEn) m_first = a;
        m_bad = 1'b1;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // Start a pass and feed nwords words; mask bit i corrupts word i.
    task automatic run_words(input logic [15:0] mask, input int nwords);
        logic [15:0] exp_word;
        exp_word = SEED;
        start    = 1'b1;
        rd_valid = 1'b0;
        step();
        start = 1'b0;
        chk("run.rd_ready", rd_ready, 1);
        chk("run.addr0", addr, 0);
        for (int i = 0; i < nwords; i++) begin
            exp_t e;
            rd_valid = 1'b1;
            rd_data  = exp_word ^ (mask[i] ? 16'h0001 : 16'h0000);
            start    = (i == 3);
            if (mask[i]) model_mismatch(AW'(i));
            e.addr  = AW'(i + 1);
            e.bad   = m_bad;
            e.err   = m_err;
            e.first = m_first;
            sb.push_back(e);
            exp_word = lfsr_step(exp_word);
            chk("run.done_low", done, 0);
            step();
            e = sb.pop_front();
            chk("sb.addr", addr, e.addr);
            chk("sb.bad", bad, e.bad);
            chk("sb.err_cnt", err_cnt, e.err);
            chk("sb.first_err_addr", first_err_addr, e.first);
        end
        start    = 1'b0;
        rd_valid = 1'b0;
        if (nwords == 16) begin
            chk("end.done", done, 1);
            chk("end.rd_ready", rd_ready, 0);
            chk("end.addr", addr, 0);
            start = 1'b1;
            step();
            start = 1'b0;
            chk("end.done_once", done, 0);
            chk("end.idle", rd_ready, 0);
            step();
            chk("end.still_idle", rd_ready, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int seen;
        vecs[0] = '{16'h0000, 8'd0,  1'b0, 4'd0};
        vecs[1] = '{16'h0020, 8'd1,  1'b1, 4'd5};
        vecs[2] = '{16'h0108, 8'd3,  1'b1, 4'd5};
        vecs[3] = '{16'hFFFF, 8'd19, 1'b1, 4'd5};
        model_clear();

        #2;
        chk("rst.bad", bad, 0);
        chk("rst.err_cnt", err_cnt, 0);
        chk("rst.first", first_err_addr, 0);
        chk("rst.addr", addr, 0);
        chk("rst.done", done, 0);
        chk("rst.rd_ready", rd_ready, 0);
        #20 rst_n = 1'b1;
        step();
        chk("idle.rd_ready", rd_ready, 0);

        for (int v = 0; v < 4; v++) begin
            run_words(vecs[v].mask, 16);
            chk("vec.err_cnt", err_cnt, vecs[v].exp_err);
            chk("vec.bad", bad, vecs[v].exp_bad);
            chk("vec.first", first_err_addr, ErrAddrEn ? vecs[v].exp_first : 4'd0);
        end

        // start and download together: download wins and clears results
        start      = 1'b1;
        dwnld_busy = 1'b1;
        step();
        start      = 1'b0;
        dwnld_busy = 1'b0;
        model_clear();
        chk("dl_start.rd_ready", rd_ready, 0);
        chk("dl_start.bad", bad, 0);
        chk("dl_start.err_cnt", err_cnt, 0);
        chk("dl_start.first", first_err_addr, 0);
        step();
        chk("dl_start.idle", rd_ready, 0);

        // Mismatch, then download coincident with a valid word
        run_words(16'h0001, 2);
        rd_valid   = 1'b1;
        rd_data    = 16'h0000;
        dwnld_busy = 1'b1;
        #1;
        chk("dl.done_gated", done, 0);
        chk("dl.in_run", rd_ready, 1);
        step();
        dwnld_busy = 1'b0;
        rd_valid   = 1'b0;
        model_clear();
        chk("dl.bad", bad, 0);
        chk("dl.err_cnt", err_cnt, 0);
        chk("dl.first", first_err_addr, 0);
        chk("dl.addr", addr, 0);
        chk("dl.rd_ready", rd_ready, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done || rd_ready) seen++;
            step();
        end
        chk("dl.no_done", seen, 0);
        chk("dl.err_after", err_cnt, 0);
        run_words(16'h0000, 16);
        chk("dl.clean_pass", err_cnt, 0);

        // Reset mid-pass at addr 7
        run_words(16'h0002, 7);
        chk("mid.addr7", addr, 7);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("mid_rst.bad", bad, 0);
        chk("mid_rst.err_cnt", err_cnt, 0);
        chk("mid_rst.first", first_err_addr, 0);
        chk("mid_rst.addr", addr, 0);
        chk("mid_rst.done", done, 0);
        chk("mid_rst.rd_ready", rd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mid_rst.no_done", done, 0);
        run_words(16'h0000, 16);
        chk("mid_rst.clean_pass", bad, 0);

        // Saturation: 3 all-wrong passes, then enough for 304 mismatches total
        for (int p = 0; p < 3; p++) run_words(16'hFFFF, 16);
        chk("sat.err48", err_cnt, 48);
        for (int p = 0; p < 16; p++) run_words(16'hFFFF, 16);
        chk("sat.errFF", err_cnt, 8'hFF);
        chk("sat.bad", bad, 1);
        run_words(16'h0000, 16);
        chk("sticky.bad", bad, 1);
        chk("sticky.err", err_cnt, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
